fir_mac_sequencer: RTL and testbench

- Sequences the shared 16x16 signed MAC slice (SB_MAC16 wrapper) to compute one FIR output per accepted audio sample.
- Holds the sample history in a circular buffer and drives coefficient-memory addresses.
- Issues one MAC operation per tap and accumulates the returned products internally.
- Returns a scaled 24-bit result with a valid/ready handshake; sits between the audio input framer and the effects output stage.

---
 rtl/fir_mac_sequencer.sv | 176 +++++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// FIR tap sequencer driving a shared 16x16 MAC slice, with circular sample history.
// Optional macro FIR_SATURATE_EN clamps the output to the 24-bit signed range.
module fir_mac_sequencer #(
  parameter int NUM_TAPS  = 32,
  parameter int MAC_LAT   = 2,
  parameter int ACC_W     = 40,
  parameter int OUT_SHIFT = 7
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [23:0]                 sample_in,
  input  logic                        sample_valid,
  output logic                        sample_ready,
  output logic [$clog2(NUM_TAPS)-1:0] coef_addr,
  input  logic [15:0]                 coef_data,
  output logic [15:0]                 mac_a,
  output logic [15:0]                 mac_b,
  output logic                        mac_ce,
  input  logic [31:0]                 mac_product,
  output logic [23:0]                 y_out,
  output logic                        y_valid,
  input  logic                        y_ready
);

  localparam int AW = $clog2(NUM_TAPS);

  localparam logic [2:0] S_CLEAR = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]              state_q, state_d;
  logic [AW-1:0]           tap_q, tap_d;
  logic [AW:0]             prod_q, prod_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [15:0]             hist_rd_q, hist_rd_d;
  logic                    ce_q, ce_d;
  logic [MAC_LAT-1:0]      pipe_q, pipe_d;
  logic [MAC_LAT:0]        pipe_cat;
  logic [23:0]             y_q, y_d;
  logic                    yv_q, yv_d;

  // Only the top 16 sample bits ever reach the multiplier.
  logic [15:0]             hist_q [NUM_TAPS];
  logic                    hist_we;
  logic [AW-1:0]           hist_wa;
  logic [15:0]             hist_wd;
  logic [AW-1:0]           hist_ra;

  logic [ACC_W-1:0]        prod_ext;
  logic [23:0]             y_tr;

  assign prod_ext = {{(ACC_W-32){mac_product[31]}}, mac_product};
  assign hist_ra  = wr_ptr_q - tap_q;
  assign pipe_cat = {pipe_q, ce_q};

`ifdef FIR_SATURATE_EN
  logic signed [ACC_W-1:0] t;
  logic                    hi_ovf, lo_ovf;

  assign t      = acc_q >>> OUT_SHIFT;
  assign hi_ovf = ~t[ACC_W-1] & (|t[ACC_W-2:23]);
  assign lo_ovf = t[ACC_W-1] & ~(&t[ACC_W-2:23]);

  always_comb begin
    y_tr = t[23:0];
    if (hi_ovf) y_tr = 24'h7FFFFF;
    if (lo_ovf) y_tr = 24'h800000;
  end
`else
  assign y_tr = acc_q[OUT_SHIFT +: 24];
`endif

  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    prod_d    = prod_q;
    wr_ptr_d  = wr_ptr_q;
    acc_d     = acc_q;
    ce_d      = 1'b0;
    y_d       = y_q;
    yv_d      = yv_q;
    hist_we   = 1'b0;
    hist_wa   = tap_q;
    hist_wd   = '0;
    hist_rd_d = hist_q[hist_ra];
    pipe_d    = pipe_cat[MAC_LAT-1:0];

    // Products land MAC_LAT cycles after their strobe.
    if (pipe_q[MAC_LAT-1]) begin
      acc_d  = acc_q + $signed(prod_ext);
      prod_d = prod_q + 1'b1;
    end

    unique case (state_q)
      S_CLEAR: begin
        hist_we = 1'b1;
        hist_wa = tap_q;
        tap_d   = tap_q + 1'b1;
        if (tap_q == AW'(NUM_TAPS - 1)) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (sample_valid) begin
          hist_we = 1'b1;
          hist_wa = wr_ptr_q;
          hist_wd = sample_in[23:8];
          acc_d   = '0;
          tap_d   = '0;
          prod_d  = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        ce_d  = 1'b1;
        tap_d = tap_q + 1'b1;
        if (tap_q == AW'(NUM_TAPS - 1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (prod_q == (AW+1)'(NUM_TAPS)) begin
          y_d      = y_tr;
          yv_d     = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (y_ready) begin
          yv_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_CLEAR;
      tap_q     <= '0;
      prod_q    <= '0;
      wr_ptr_q  <= '0;
      acc_q     <= '0;
      hist_rd_q <= '0;
      ce_q      <= 1'b0;
      pipe_q    <= '0;
      y_q       <= '0;
      yv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      prod_q    <= prod_d;
      wr_ptr_q  <= wr_ptr_d;
      acc_q     <= acc_d;
      hist_rd_q <= hist_rd_d;
      ce_q      <= ce_d;
      pipe_q    <= pipe_d;
      y_q       <= y_d;
      yv_q      <= yv_d;
    end
  end

  always_ff @(posedge clk) begin
    if (hist_we) hist_q[hist_wa] <= hist_wd;
  end

  assign sample_ready = (state_q == S_IDLE);
  assign coef_addr    = tap_q;
  assign mac_ce       = ce_q;
  assign mac_a        = ce_q ? coef_data : 16'h0000;
  assign mac_b        = ce_q ? hist_rd_q : 16'h0000;
  assign y_out        = y_q;
  assign y_valid      = yv_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with NUM_TAPS=4, MAC_LAT=2.
// Expectations follow FIR_SATURATE_EN when the macro is defined.
module tb_fir_mac_sequencer;

  localparam int N = 4;

  logic        clk;
  logic        reset_n;
  logic [23:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic [1:0]  coef_addr;
  logic [15:0] coef_data;
  logic [15:0] mac_a;
  logic [15:0] mac_b;
  logic        mac_ce;
  logic [31:0] mac_product;
  logic [23:0] y_out;
  logic        y_valid;
  logic        y_ready;

  int n_vec;
  int n_err;
  int ce_tot;

  logic [15:0] coefs [N];
  logic [31:0] p0, p1;

  fir_mac_sequencer #(
    .NUM_TAPS(4), .MAC_LAT(2), .ACC_W(40), .OUT_SHIFT(7)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .coef_addr(coef_addr),
    .coef_data(coef_data), .mac_a(mac_a), .mac_b(mac_b),
    .mac_ce(mac_ce), .mac_product(mac_product),
    .y_out(y_out), .y_valid(y_valid), .y_ready(y_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) coef_data <= coefs[coef_addr];

  always @(posedge clk) begin
    p0 <= $signed(mac_a) * $signed(mac_b);
    p1 <= p0;
  end
  assign mac_product = p1;

  initial ce_tot = 0;
  always @(posedge clk) if (mac_ce) ce_tot <= ce_tot + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_coefs(input logic [15:0] c0, input logic [15:0] c1,
                           input logic [15:0] c2, input logic [15:0] c3);
    coefs[0] = c0; coefs[1] = c1; coefs[2] = c2; coefs[3] = c3;
  endtask

  task automatic wait_clear();
    int n;
    n = 0;
    while (!sample_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("clr_len", n, N);
  endtask

  task automatic send(input logic [23:0] s, input logic [23:0] exp);
    int n;
    int c0;
    n = 0;
    while (!sample_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("rdy", sample_ready, 1);
    sample_in = s;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    c0 = ce_tot;
    n = 0;
    while (!y_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("lat", n, 8);
    chk("y", y_out, exp);
    chk("ce_n", ce_tot - c0, N);
    if (y_ready) begin
      @(posedge clk); #1;
      chk("vdrop", y_valid, 0);
    end
  endtask

  logic [23:0] ramp_exp [7];
  logic [23:0] sat_exp [4];
  logic [23:0] yhold;
  int          bad;

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n = 1'b0;
    sample_in = '0;
    sample_valid = 1'b0;
    y_ready = 1'b1;
    set_coefs(16'h4000, 16'h2000, 16'h1000, 16'h0800);
    ramp_exp[0] = 24'h0000FF; ramp_exp[1] = 24'h0001FF;
    ramp_exp[2] = 24'h0002FF; ramp_exp[3] = 24'h0003FF;
    ramp_exp[4] = 24'h0004FF; ramp_exp[5] = 24'h0005FF;
    ramp_exp[6] = 24'h0006FF;
`ifdef FIR_SATURATE_EN
    sat_exp[0] = 24'h7FFE00; sat_exp[1] = 24'h7FFFFF;
    sat_exp[2] = 24'h7FFFFF; sat_exp[3] = 24'h7FFFFF;
`else
    sat_exp[0] = 24'h7FFE00; sat_exp[1] = 24'hFFFC00;
    sat_exp[2] = 24'h7FFA00; sat_exp[3] = 24'hFFF800;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", sample_ready, 0);
    chk("rst_yv", y_valid, 0);
    chk("rst_y", y_out, 0);
    chk("rst_ce", mac_ce, 0);
    chk("rst_a", mac_a, 0);
    chk("rst_b", mac_b, 0);
    chk("rst_addr", coef_addr, 0);
    reset_n = 1'b1;
    wait_clear();

    send(24'h000000, 24'h000000);

    send(24'h7FFF00, 24'h3FFF80);
    send(24'h000000, 24'h1FFFC0);
    send(24'h000000, 24'h0FFFE0);
    send(24'h000000, 24'h07FFF0);

    set_coefs(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    for (int i = 0; i < 4; i++) send(24'h7FFF00, sat_exp[i]);

    set_coefs(16'h7FFF, 16'h0000, 16'h0000, 16'h0000);
    y_ready = 1'b0;
    send(24'h000100, 24'h0000FF);
    yhold = y_out;
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (y_out !== yhold || sample_ready || !y_valid || mac_ce) bad++;
    end
    chk("bp_hold", bad, 0);
    y_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_vdrop", y_valid, 0);
    chk("bp_rdy", sample_ready, 1);

    for (int n = 1; n <= 7; n++) send(24'(n << 8), ramp_exp[n-1]);

    send(24'hFFFF00, 24'hFFFF00);

    set_coefs(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    sample_in = 24'h7FFF00;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_ce_pre", mac_ce, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_ce", mac_ce, 0);
    chk("mid_yv", y_valid, 0);
    chk("mid_rdy", sample_ready, 0);
    chk("mid_addr", coef_addr, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    wait_clear();
    send(24'h000100, 24'h0000FF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
